fp8_operand_loader: RTL and testbench

//   Upstream feeder for the FP8 (1-4-3, bias 7) multiplier. Accepts a nibble stream under valid/ready,

---
 rtl/fp8_operand_loader.sv | 157 +++++++++++++++
 tb/tb_fp8_operand_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp8_operand_loader.sv
// fp8_operand_loader
//   Assembles a valid/ready nibble stream into an FP8 operand pair (A, then B)
//   and holds the pair stable under valid/ready until the multiplier takes it.
//   Two states: COLLECT accepts nibbles, HOLD presents the finished pair.
//   Optional feature: define FP8_LOADER_NAN_FLAG_EN to register a NaN flag
//   (operand equal to the negative-zero encoding) with each pair. Without the
//   macro, nan_flag is tied low.
module fp8_operand_loader #(
   parameter int DATA_W    = 8,
   parameter int NIB_W     = 4,
   parameter int LSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [NIB_W-1:0]  in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic              ops_valid,
   input  logic              ops_ready,
   output logic              nan_flag,
   output logic [7:0]        pair_count
);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   localparam bit LO_FIRST = (LSB_FIRST != 0);

   state_t            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [DATA_W-1:0] sha_q, sha_d;
   logic [DATA_W-1:0] shb_q, shb_d;
   logic [DATA_W-1:0] op_a_q, op_a_d;
   logic [DATA_W-1:0] op_b_q, op_b_d;
   logic [7:0]        pair_count_q, pair_count_d;

   // Shadow registers with the nibble accepted this cycle already merged in;
   // on the fourth accept these are the operands that get published.
   logic [DATA_W-1:0] asm_a, asm_b;
   logic              accept, handoff, last_nib, write_high;

   // Next-state logic: nibble placement, pair publication, handoff and flush.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      accept       = (state_q == COLLECT) && in_valid;
      handoff      = (state_q == HOLD) && ops_ready;
      last_nib     = (idx_q == 2'd3);
      // Odd idx is the second nibble of an operand; which half that is depends on order.
      write_high   = LO_FIRST ? idx_q[0] : ~idx_q[0];

      asm_a        = sha_q;
      asm_b        = shb_q;
      state_d      = state_q;
      idx_d        = idx_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      pair_count_d = pair_count_q;

      if (accept) begin
         if (!idx_q[1]) begin
            if (write_high) asm_a[NIB_W +: NIB_W] = in_data;
            else            asm_a[0 +: NIB_W]     = in_data;
         end else begin
            if (write_high) asm_b[NIB_W +: NIB_W] = in_data;
            else            asm_b[0 +: NIB_W]     = in_data;
         end

         if (last_nib) begin
            op_a_d  = asm_a;
            op_b_d  = asm_b;
            idx_d   = 2'd0;
            state_d = HOLD;
         end else begin
            idx_d = idx_q + 2'd1;
         end
      end

      sha_d = asm_a;
      shb_d = asm_b;

      if (handoff) begin
         state_d      = COLLECT;
         pair_count_d = pair_count_q + 8'd1;
      end

      // Flush abandons the pair in flight: a pair completing or being taken
      // this cycle is neither published nor counted.
      if (flush) begin
         state_d      = COLLECT;
         idx_d        = 2'd0;
         sha_d        = '0;
         shb_d        = '0;
         op_a_d       = op_a_q;
         op_b_d       = op_b_q;
         pair_count_d = pair_count_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q      <= COLLECT;
         idx_q        <= 2'd0;
         sha_q        <= '0;
         shb_q        <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         pair_count_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         sha_q        <= sha_d;
         shb_q        <= shb_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         pair_count_q <= pair_count_d;
      end
   end

`ifdef FP8_LOADER_NAN_FLAG_EN
   localparam logic [DATA_W-1:0] NAN_CODE = {1'b1, {(DATA_W-1){1'b0}}};

   logic nan_q, nan_d;

   // NaN flag captured alongside the operands when a pair is published.
   always_comb begin
      nan_d = nan_q;
      if (accept && last_nib) nan_d = (asm_a == NAN_CODE) || (asm_b == NAN_CODE);
      if (flush)              nan_d = 1'b0;
   end

   // NaN flag register.
   always_ff @(posedge clk) begin
      if (rst) nan_q <= 1'b0;
      else     nan_q <= nan_d;
   end

   assign nan_flag = nan_q;
`else
   assign nan_flag = 1'b0;
`endif

   // Handshake outputs decode the state register only, so in_ready has no
   // combinational path from in_valid or ops_ready.
   assign in_ready   = (state_q == COLLECT);
   assign ops_valid  = (state_q == HOLD);
   assign op_a       = op_a_q;
   assign op_b       = op_b_q;
   assign pair_count = pair_count_q;

endmodule

// File: tb/tb_fp8_operand_loader.sv
// Bench for fp8_operand_loader: one instance per nibble order, driven by the
// same stimulus, each compared against hand-computed operands.
module tb_fp8_operand_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic [3:0] in_data;
   logic       in_valid;
   logic       ops_ready;

   logic       in_ready_l, ops_valid_l, nan_l;
   logic [7:0] op_a_l, op_b_l, cnt_l;
   logic       in_ready_m, ops_valid_m, nan_m;
   logic [7:0] op_a_m, op_b_m, cnt_m;

`ifdef FP8_LOADER_NAN_FLAG_EN
   localparam bit NAN_EN = 1'b1;
`else
   localparam bit NAN_EN = 1'b0;
`endif

   int total = 0;
   int bad   = 0;
   int exp_count = 0;

   always #5 clk = ~clk;

   fp8_operand_loader #(.DATA_W(8), .NIB_W(4), .LSB_FIRST(1)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
      .op_a(op_a_l), .op_b(op_b_l), .ops_valid(ops_valid_l), .ops_ready(ops_ready),
      .nan_flag(nan_l), .pair_count(cnt_l)
   );

   fp8_operand_loader #(.DATA_W(8), .NIB_W(4), .LSB_FIRST(0)) u_dut_msb (
      .clk(clk), .rst(rst), .flush(flush),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_m),
      .op_a(op_a_m), .op_b(op_b_m), .ops_valid(ops_valid_m), .ops_ready(ops_ready),
      .nan_flag(nan_m), .pair_count(cnt_m)
   );

   // Nibble arrival order is nibs[15:12], [11:8], [7:4], [3:0].
   typedef struct {
      logic [15:0] nibs;
      logic [7:0]  a_l;
      logic [7:0]  b_l;
      logic        nan_l;
      logic [7:0]  a_m;
      logic [7:0]  b_m;
      logic        nan_m;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send_nib(input logic [3:0] n);
      in_valid = 1'b1;
      in_data  = n;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_pair(input logic [15:0] nibs);
      for (int i = 0; i < 4; i++) begin
         send_nib(nibs[15-4*i -: 4]);
         if (i == 2) check("ops_valid_before_4th", {31'd0, ops_valid_l}, 32'd0);
      end
      check("ops_valid_after_4th_l", {31'd0, ops_valid_l}, 32'd1);
      check("ops_valid_after_4th_m", {31'd0, ops_valid_m}, 32'd1);
      check("in_ready_hold", {31'd0, in_ready_l}, 32'd0);
   endtask

   task automatic do_handoff();
      ops_ready = 1'b1;
      @(negedge clk);
      ops_ready = 1'b0;
      exp_count++;
      check("ops_valid_after_handoff", {31'd0, ops_valid_l}, 32'd0);
      check("in_ready_after_handoff", {31'd0, in_ready_l}, 32'd1);
      check("pair_count_l", {24'd0, cnt_l}, exp_count & 32'hFF);
      check("pair_count_m", {24'd0, cnt_m}, exp_count & 32'hFF);
   endtask

   initial begin
      vecs[0] = '{16'h8304, 8'h38, 8'h40, 1'b0, 8'h83, 8'h04, 1'b0};
      vecs[1] = '{16'h0801, 8'h80, 8'h10, 1'b1, 8'h08, 8'h01, 1'b0};
      vecs[2] = '{16'h3840, 8'h83, 8'h04, 1'b0, 8'h38, 8'h40, 1'b0};
      vecs[3] = '{16'hFF00, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0};
      vecs[4] = '{16'h0008, 8'h00, 8'h80, 1'b1, 8'h00, 8'h08, 1'b0};
      vecs[5] = '{16'h8008, 8'h08, 8'h80, 1'b1, 8'h80, 8'h08, 1'b1};
      vecs[6] = '{16'hA5C3, 8'h5A, 8'h3C, 1'b0, 8'hA5, 8'hC3, 1'b0};

      rst = 1'b1; flush = 1'b0; in_data = 4'd0; in_valid = 1'b0; ops_ready = 1'b0;

      // Reset state.
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready_l}, 32'd1);
      check("rst_ops_valid", {31'd0, ops_valid_l}, 32'd0);
      check("rst_op_a", {24'd0, op_a_l}, 32'd0);
      check("rst_op_b", {24'd0, op_b_l}, 32'd0);
      check("rst_pair_count", {24'd0, cnt_l}, 32'd0);
      check("rst_nan", {31'd0, nan_l}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", {31'd0, in_ready_m}, 32'd1);

      // Table of pairs: load, compare both orders, hand off.
      for (int v = 0; v < 7; v++) begin
         send_pair(vecs[v].nibs);
         check($sformatf("v%0d_op_a_l", v), {24'd0, op_a_l}, {24'd0, vecs[v].a_l});
         check($sformatf("v%0d_op_b_l", v), {24'd0, op_b_l}, {24'd0, vecs[v].b_l});
         check($sformatf("v%0d_op_a_m", v), {24'd0, op_a_m}, {24'd0, vecs[v].a_m});
         check($sformatf("v%0d_op_b_m", v), {24'd0, op_b_m}, {24'd0, vecs[v].b_m});
         check($sformatf("v%0d_nan_l", v), {31'd0, nan_l}, {31'd0, NAN_EN & vecs[v].nan_l});
         check($sformatf("v%0d_nan_m", v), {31'd0, nan_m}, {31'd0, NAN_EN & vecs[v].nan_m});
         do_handoff();
         check($sformatf("v%0d_op_a_retained", v), {24'd0, op_a_l}, {24'd0, vecs[v].a_l});
      end

      // Back-pressure in HOLD: nibbles offered but not consumed.
      send_pair(16'h1234);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; in_data = 4'h9;
         @(negedge clk);
         check("bp_ops_valid", {31'd0, ops_valid_l}, 32'd1);
         check("bp_in_ready", {31'd0, in_ready_l}, 32'd0);
         check("bp_op_a_l", {24'd0, op_a_l}, 32'h21);
         check("bp_op_b_m", {24'd0, op_b_m}, 32'h34);
      end
      in_valid = 1'b0;
      do_handoff();

      // Flush mid-collection drops partial pair and the nibble offered with it.
      send_nib(4'h1);
      send_nib(4'h2);
      flush = 1'b1; in_valid = 1'b1; in_data = 4'h9;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      check("flush_in_ready", {31'd0, in_ready_l}, 32'd1);
      check("flush_ops_valid", {31'd0, ops_valid_l}, 32'd0);
      check("flush_op_a_kept", {24'd0, op_a_l}, 32'h21);
      check("flush_pair_count", {24'd0, cnt_l}, exp_count & 32'hFF);
      send_pair(16'h5678);
      check("post_flush_op_a_l", {24'd0, op_a_l}, 32'h65);
      check("post_flush_op_b_l", {24'd0, op_b_l}, 32'h87);
      check("post_flush_op_a_m", {24'd0, op_a_m}, 32'h56);
      check("post_flush_op_b_m", {24'd0, op_b_m}, 32'h78);

      // Flush in HOLD while the consumer takes the pair: not counted.
      flush = 1'b1; ops_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; ops_ready = 1'b0;
      check("hold_flush_ops_valid", {31'd0, ops_valid_l}, 32'd0);
      check("hold_flush_in_ready", {31'd0, in_ready_l}, 32'd1);
      check("hold_flush_count", {24'd0, cnt_l}, exp_count & 32'hFF);
      check("hold_flush_op_a_kept", {24'd0, op_a_l}, 32'h65);
      check("hold_flush_nan", {31'd0, nan_l}, 32'd0);

      // 256 back-to-back pairs: counter wraps through 255->0 back to its start.
      begin
         int start_count;
         start_count = exp_count & 32'hFF;
         for (int p = 0; p < 256; p++) begin
            send_pair(16'h3840);
            if (p == 0) begin
               check("wrap_op_a_m", {24'd0, op_a_m}, 32'h38);
               check("wrap_op_b_m", {24'd0, op_b_m}, 32'h40);
            end
            do_handoff();
         end
         check("wrap_full_cycle", {24'd0, cnt_l}, start_count);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
